// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC operand feeder.
package mac_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 24;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StStream,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO; full/empty come from an occupancy count, pointers wrap modulo DEPTH.
module byte_fifo
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              wr_en, rd_en;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  // A write while full is dropped even if a pop happens on the same edge.
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;
  assign dout  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mac_feeder.sv
// Streams VEC_LEN operand pairs from two FIFOs into a MAC with a registered multiplier,
// sequencing clear, accumulate enables and a completion pulse.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned VEC_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_wr,
  input  logic [DATA_W-1:0] a_din,
  input  logic              b_wr,
  input  logic [DATA_W-1:0] b_din,
  input  logic              start,
  output logic              a_full,
  output logic              b_full,
  output logic [DATA_W-1:0] Ain,
  output logic [DATA_W-1:0] Bin,
  output logic              En,
  output logic              Clr,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] LastIdx = 8'(VEC_LEN - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              drain_q, drain_d;
  logic              pop, pop_d1_q, en_q;
  logic [DATA_W-1:0] ain_q, bin_q, a_dout, b_dout;
  logic              a_empty, b_empty;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (a_wr),
    .din   (a_din),
    .rd    (pop),
    .dout  (a_dout),
    .full  (a_full),
    .empty (a_empty)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (b_wr),
    .din   (b_din),
    .rd    (pop),
    .dout  (b_dout),
    .full  (b_full),
    .empty (b_empty)
  );

  // Both FIFOs pop together or not at all.
  assign pop = (state_q == StStream) & ~a_empty & ~b_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: if (start) state_d = StClr;
      StClr: begin
        cnt_d   = '0;
        drain_d = 1'b0;
        state_d = StStream;
      end
      StStream: begin
        if (pop) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LastIdx) state_d = StDrain;
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      drain_q  <= 1'b0;
      pop_d1_q <= 1'b0;
      en_q     <= 1'b0;
      ain_q    <= '0;
      bin_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      // Two-stage delay lines the enable up with the multiplier register downstream.
      pop_d1_q <= pop;
      en_q     <= pop_d1_q;
      if (pop) begin
        ain_q <= a_dout;
        bin_q <= b_dout;
      end
    end
  end

  assign Ain  = ain_q;
  assign Bin  = bin_q;
  assign En   = en_q;
  assign Clr  = (state_q == StClr);
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder with an attached behavioural MAC and pair-queue model.
module tb_mac_feeder;

  localparam int DEPTH   = 8;
  localparam int VEC_LEN = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_wr = 1'b0, b_wr = 1'b0, start = 1'b0;
  logic [7:0] a_din = '0, b_din = '0;
  logic       a_full, b_full, En, Clr, busy, done;
  logic [7:0] Ain, Bin;

  mac_feeder #(.DEPTH(DEPTH), .VEC_LEN(VEC_LEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_wr   (a_wr),
    .a_din  (a_din),
    .b_wr   (b_wr),
    .b_din  (b_din),
    .start  (start),
    .a_full (a_full),
    .b_full (b_full),
    .Ain    (Ain),
    .Bin    (Bin),
    .En     (En),
    .Clr    (Clr),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Downstream MAC: registered multiplier then accumulator.
  logic [15:0] prod;
  logic [23:0] acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      prod <= Ain * Bin;
      if (Clr)     acc <= '0;
      else if (En) acc <= acc + 24'(prod);
    end
  end

  int n_checks = 0, n_fail = 0;
  int cyc = 0, en_cnt = 0, clr_cnt = 0, done_cnt = 0, first_en = 0, last_en = 0, viol = 0;
  logic [23:0] cout_done = '0;
  logic [7:0]  qa[$], qb[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (En) begin
        if (en_cnt == 0) first_en = cyc;
        last_en = cyc;
        en_cnt++;
      end
      if (Clr) clr_cnt++;
      if (done) begin
        done_cnt++;
        cout_done = acc;
      end
      if (En && (done || !busy)) viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [23:0] exp_dot();
    logic [23:0] s = '0;
    for (int i = 0; i < VEC_LEN; i++) s += 24'(qa.pop_front()) * 24'(qb.pop_front());
    return s;
  endfunction

  // Called at a negedge; waits for room in both FIFOs, then writes one pair.
  task automatic drive_pair(input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    while ((a_full || b_full) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      n_checks++; n_fail++;
      $display("FAIL drive_pair: FIFO stayed full, got full=1 expected space");
    end
    a_wr = 1'b1; b_wr = 1'b1; a_din = a; b_din = b;
    qa.push_back(a); qb.push_back(b);
    @(negedge clk);
    a_wr = 1'b0; b_wr = 1'b0;
  endtask

  task automatic run_and_check(input string name);
    logic [23:0] exp;
    int t = 0;
    en_cnt = 0; clr_cnt = 0; done_cnt = 0; viol = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (done_cnt == 0) begin
      n_fail++;
      $display("FAIL %s_done: got no done pulse, expected one", name);
    end
    exp = exp_dot();
    n_checks++;
    if (cout_done !== exp) begin
      n_fail++; $display("FAIL %s_cout: got %0d expected %0d", name, cout_done, exp);
    end
    n_checks++;
    if (en_cnt !== VEC_LEN) begin
      n_fail++; $display("FAIL %s_en_count: got %0d expected %0d", name, en_cnt, VEC_LEN);
    end
    n_checks++;
    if (clr_cnt !== 1) begin
      n_fail++; $display("FAIL %s_clr_count: got %0d expected 1", name, clr_cnt);
    end
    n_checks++;
    if (viol !== 0) begin
      n_fail++; $display("FAIL %s_en_outside_run: got %0d expected 0", name, viol);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_idle_after: got busy=%b expected 0", name, busy);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [7:0] got;
    got = {Ain == 0, Bin == 0, !En, !Clr, !busy, !done, !a_full, !b_full};
    n_checks++;
    if (got !== 8'hff) begin
      n_fail++;
      $display("FAIL %s: got Ain=%0d Bin=%0d En=%b Clr=%b busy=%b done=%b af=%b bf=%b expected all 0",
               name, Ain, Bin, En, Clr, busy, done, a_full, b_full);
    end
  endtask

  task automatic test_reset();
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 8; i++) drive_pair(8'(i), 8'(i));
    run_and_check("basic");
    n_checks++;
    if (last_en - first_en !== VEC_LEN - 1) begin
      n_fail++;
      $display("FAIL basic_contiguous: got span %0d expected %0d", last_en - first_en, VEC_LEN - 1);
    end
  endtask

  task automatic test_stall();
    fork
      run_and_check("stall");
      begin
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
          drive_pair(8'(i), 8'(i));
          repeat (2) @(negedge clk);
        end
      end
    join
    n_checks++;
    if (last_en - first_en !== 3 * (VEC_LEN - 1)) begin
      n_fail++;
      $display("FAIL stall_gaps: got span %0d expected %0d", last_en - first_en, 3 * (VEC_LEN - 1));
    end
  endtask

  task automatic test_overflow();
    logic exp_full;
    for (int i = 1; i <= 9; i++) begin
      exp_full = (qa.size() >= DEPTH);
      n_checks++;
      if (a_full !== exp_full) begin
        n_fail++; $display("FAIL overflow_full_%0d: got %b expected %b", i, a_full, exp_full);
      end
      a_wr = 1'b1; a_din = 8'(i);
      if (!exp_full) qa.push_back(8'(i));
      @(negedge clk);
    end
    a_wr = 1'b0;
    n_checks++;
    if (a_full !== 1'b1) begin
      n_fail++; $display("FAIL overflow_full_end: got %b expected 1", a_full);
    end
    for (int i = 1; i <= 8; i++) begin
      b_wr = 1'b1; b_din = 8'(i); qb.push_back(8'(i));
      @(negedge clk);
    end
    b_wr = 1'b0;
    run_and_check("overflow");
    n_checks++;
    if (a_full !== 1'b0) begin
      n_fail++; $display("FAIL overflow_drained: got a_full=%b expected 0", a_full);
    end
    for (int i = 0; i < VEC_LEN; i++) drive_pair(8'($urandom_range(0, 255)), 8'(100 + i));
    run_and_check("after_drop");
  endtask

  task automatic test_busy_start();
    for (int i = 0; i < VEC_LEN; i++) drive_pair(8'($urandom), 8'($urandom));
    fork
      run_and_check("busy_start");
      begin
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_single: got done=%0d busy=%b expected 1 and 0", done_cnt, busy);
    end
  endtask

  task automatic test_wrap();
    fork
      for (int i = 0; i < 16; i++) drive_pair(8'd2, 8'd3);
      begin
        run_and_check("wrap_run1");
        run_and_check("wrap_run2");
      end
    join
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      fork
        run_and_check($sformatf("random%0d", r));
        begin
          int n = VEC_LEN - qa.size() + int'($urandom_range(0, 3));
          for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive_pair(8'($urandom), 8'($urandom));
          end
        end
      join
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int need = VEC_LEN - qa.size();
    for (int i = 0; i < need; i++) drive_pair(8'($urandom), 8'($urandom));
    en_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (en_cnt < 4 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (en_cnt < 4) begin
      n_fail++; $display("FAIL reset_mid_reach: got %0d En pulses expected 4", en_cnt);
    end
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_outputs");
    qa.delete(); qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    // The first edge after release must take a write.
    for (int i = 0; i < DEPTH - 1; i++) drive_pair(8'($urandom), 8'($urandom));
    n_checks++;
    if (a_full !== 1'b0 || b_full !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_empty: got af=%b bf=%b busy=%b expected 0 0 0", a_full, b_full, busy);
    end
    drive_pair(8'($urandom), 8'($urandom));
    n_checks++;
    if (a_full !== 1'b1 || b_full !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_fill: got af=%b bf=%b expected 1 1", a_full, b_full);
    end
    run_and_check("reset_mid_rerun");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_busy_start();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter DEPTH, default 8: entries per operand FIFO; power of two, at least 2.
REQ-002 Parameter VEC_LEN, default 8: operand pairs per dot product; 1..255.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port a_wr, input, 1: write strobe for the A operand FIFO.
REQ-006 Port a_din, input, 8: A operand byte, unsigned.
REQ-007 Port b_wr, input, 1: write strobe for the B operand FIFO.
REQ-008 Port b_din, input, 8: B operand byte, unsigned.
REQ-009 Port start, input, 1: one-cycle request to begin one VEC_LEN-pair dot product.
REQ-010 Port a_full / b_full, output, 1 each: FIFO full flags.
REQ-011 Port Ain / Bin, output, 8 each: registered operands driving the MAC.
REQ-012 Port En / Clr, output, 1 each: MAC accumulate enable and clear.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port done, output, 1: one-cycle pulse when the MAC result is final.

Function
REQ-015 A write SHALL be accepted only when its FIFO is not full; a write while full is dropped with no state change, even if a pop occurs in the same cycle.
REQ-016 The FSM SHALL have the states IDLE, CLR, STREAM, DRAIN and DONE.
REQ-017 Transitions: IDLE->CLR on start; CLR->STREAM after 1 cycle; STREAM->DRAIN after the VEC_LEN-th pop; DRAIN->DONE after 2 cycles; DONE->IDLE after 1 cycle.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 Clr SHALL be high exactly during the CLR cycle.
REQ-020 In STREAM, one pair SHALL pop per cycle when both FIFOs are non-empty; when either FIFO is empty there is no pop (a stall), and neither FIFO is popped.
REQ-021 A pair popped at edge t SHALL appear on Ain/Bin from t+1; Ain/Bin SHALL hold their last value between pops.
REQ-022 En SHALL be the pop strobe delayed exactly 2 cycles, which matches the downstream registered multiplier stage; stalls propagate as En=0 gaps.
REQ-023 The pop counter SHALL be 8 bits, clear in CLR, and never exceed VEC_LEN.
REQ-024 done SHALL pulse in the DONE cycle, which is the cycle after the final En; En is never high in DONE or IDLE.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from an occupancy count of width $clog2(DEPTH)+1.
REQ-026 FIFO contents beyond VEC_LEN pairs SHALL remain queued for the next start.

Reset
REQ-027 On rst_n low, FSM=IDLE, FIFOs empty, counter=0, Ain=Bin=0, En=Clr=done=busy=0, and the En delay line is cleared, regardless of operation in progress.
REQ-028 After reset deasserts, the block SHALL accept writes on the first clk edge.

Structure
REQ-029 The shared package mac_pkg SHALL hold the FSM state enum, DATA_W=8 and ACC_W=24.
REQ-030 Each operand FIFO SHALL be one instance of the sub-module byte_fifo (parameter DEPTH; ports clk, rst_n, wr, din, rd, dout, full, empty).

Verification
REQ-031 Write A=1..8 and B=1..8, then pulse start -> Clr 1 cycle, 8 contiguous En pulses, done; the attached mac reports Cout=204.
REQ-032 Start with both FIFOs empty, then write pairs every 3rd cycle -> En gaps mirror the stalls, still exactly 8 En pulses, and Cout=204.
REQ-033 Write 9 bytes to A with DEPTH=8 -> a_full high after the 8th write; the 9th byte is dropped and never popped.
REQ-034 Assert rst_n low mid-STREAM after 4 En pulses -> all outputs are 0 immediately; after release, busy=0 and both FIFOs are empty.
REQ-035 Pulse start again while busy -> no effect; exactly one done pulse.
REQ-036 Load 16 pairs of 2x3 and run two starts -> each run gives Cout=48, Clr clears between runs, and the pointers wrap correctly.
